// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage LC-3b pipeline. It produces the stage load
// enables and NOP-insert controls, and keeps saturating stall and flush counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_access,
  input  logic        dmem_resp,
  input  logic        mem_indirect,
  input  logic        br_taken,
  input  logic        ex_load,
  input  logic [2:0]  ex_dest,
  input  logic        id_uses_sr1,
  input  logic        id_uses_sr2,
  input  logic [2:0]  id_sr1,
  input  logic [2:0]  id_sr2,
  input  logic        cnt_clear,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        bubble_if_id,
  output logic        bubble_id_ex,
  output logic        bubble_ex_mem,
  output logic        mem_ind_phase,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IND   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  logic        dmem_stall;
  logic        lu_hazard;
  logic        imem_wait;
  logic        squash;

  assign dmem_stall = (dmem_access && !dmem_resp) || ((state_q == IND) && !dmem_resp);
  assign lu_hazard  = ex_load && ((id_uses_sr1 && (id_sr1 == ex_dest)) ||
                                  (id_uses_sr2 && (id_sr2 == ex_dest)));
  assign imem_wait  = imem_read && !imem_resp;

  // Stage enables, bubble controls and next state, in priority order.
  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    bubble_if_id  = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    mem_ind_phase = 1'b0;
    squash        = 1'b0;
    state_d       = state_q;
    if (reset) begin
      state_d = RUN;
    end else if (dmem_stall) begin
      mem_ind_phase = (state_q == IND);
    end else if ((state_q == RUN) && mem_indirect && dmem_resp) begin
      // First indirect access done: freeze everything for the data access.
      state_d = IND;
    end else if (state_q == DRAIN) begin
      load_if_id   = 1'b1;
      bubble_if_id = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      state_d      = imem_resp ? RUN : DRAIN;
    end else begin
      mem_ind_phase = (state_q == IND);
      state_d       = RUN;
      load_ex_mem   = 1'b1;
      load_mem_wb   = 1'b1;
      load_id_ex    = 1'b1;
      if (br_taken) begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        bubble_if_id  = 1'b1;
        bubble_id_ex  = 1'b1;
        bubble_ex_mem = 1'b1;
        squash        = 1'b1;
        state_d       = imem_wait ? DRAIN : RUN;
      end else if (lu_hazard) begin
        bubble_id_ex = 1'b1;
      end else if (imem_wait) begin
        load_if_id   = 1'b1;
        bubble_if_id = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

  // Saturating counters; clear wins over increment.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clear) begin
      stall_d = 16'd0;
      flush_d = 16'd0;
    end else begin
      if (!reset && !load_pc && (stall_q != 16'hFFFF)) begin
        stall_d = stall_q + 16'd1;
      end else begin
        stall_d = stall_q;
      end
      if (squash && (flush_q != 16'hFFFF)) begin
        flush_d = flush_q + 16'd1;
      end else begin
        flush_d = flush_q;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule
